alu_cmd_sequencer: RTL

Command-side controller for the 16-bit `alu` datapath. It accepts one operation at a time (opcode plus three operands) over a valid/ready port and drives registered, stable operands and control onto the ALU. After a fixed settle time it captures `result` and `z` and returns them over a valid/ready response port. It replaces free-running stimulus with a handshaked issuer that a CPU control path or test harness can sit behind.

---
 rtl/alu_cmd_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Handshaked command issuer for the 16-bit alu datapath: holds operands stable for SETTLE
// cycles, captures result/zero flag, returns them. Define ALU_SEQ_ZCOUNT_EN to add zero_count.
module alu_cmd_sequencer #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2,
  parameter int MAX_OP = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIDTH-1:0] cmd_c,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_c,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_z,
  output logic             rsp_err,
`ifdef ALU_SEQ_ZCOUNT_EN
  output logic [15:0]      zero_count,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [4:0] MAX_OP_L    = 5'(MAX_OP);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg;
  logic [WIDTH-1:0] alu_a_reg, alu_b_reg, alu_c_reg;
  logic [3:0]       alu_ctrl_reg;
  logic [WIDTH-1:0] rsp_result_reg;
  logic             rsp_z_reg, rsp_err_reg;
  logic             op_legal, cmd_fire, settle_done, rsp_fire;

  assign op_legal  = ({1'b0, cmd_op} <= MAX_OP_L);
  assign cmd_ready = reset_n && (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    cmd_fire    = 1'b0;
    settle_done = 1'b0;
    rsp_fire    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_fire   = 1'b1;
          state_next = op_legal ? DRIVE : RESP;
        end
      end
      DRIVE: begin
        if (cnt_reg == SETTLE_LAST) begin
          settle_done = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU operands only change on a legal accept, so they are stable through DRIVE and RESP.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_reg        <= 4'd0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_c_reg      <= '0;
      alu_ctrl_reg   <= 4'd0;
      rsp_result_reg <= '0;
      rsp_z_reg      <= 1'b0;
      rsp_err_reg    <= 1'b0;
    end else begin
      if (cmd_fire && op_legal) begin
        alu_a_reg    <= cmd_a;
        alu_b_reg    <= cmd_b;
        alu_c_reg    <= cmd_c;
        alu_ctrl_reg <= cmd_op;
        cnt_reg      <= 4'd0;
      end else if (state_reg == DRIVE) begin
        cnt_reg <= cnt_reg + 4'd1;
      end
      if (cmd_fire && !op_legal) begin
        rsp_result_reg <= '0;
        rsp_z_reg      <= 1'b0;
        rsp_err_reg    <= 1'b1;
      end
      if (settle_done) begin
        rsp_result_reg <= alu_result;
        rsp_z_reg      <= alu_z;
        rsp_err_reg    <= 1'b0;
      end
    end
  end

  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_c      = alu_c_reg;
  assign alu_ctrl   = alu_ctrl_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_z      = rsp_z_reg;
  assign rsp_err    = rsp_err_reg;

`ifdef ALU_SEQ_ZCOUNT_EN
  logic [15:0] zero_count_reg;

  // Saturating count of delivered, non-error responses whose zero flag was set.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      zero_count_reg <= 16'd0;
    end else if (rsp_fire && rsp_z_reg && !rsp_err_reg && (zero_count_reg != 16'hFFFF)) begin
      zero_count_reg <= zero_count_reg + 16'd1;
    end
  end

  assign zero_count = zero_count_reg;
`else
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
`endif

endmodule
